// File: rtl/divekick_pkg.sv
// Shared encodings for the fight judge: fighter poses, sprite geometry,
// kick/body hit-box offsets relative to a sprite's top-left, and FSM states.
package divekick_pkg;

  typedef enum logic [2:0] {
    POSE_GROUND      = 3'd0,
    POSE_JUMP        = 3'd1,
    POSE_KICK_R      = 3'd2,
    POSE_BACK_GROUND = 3'd3,
    POSE_BACK_JUMP   = 3'd4,
    POSE_KICK_L      = 3'd5
  } pose_e;

  localparam int SPRITE_W = 72;
  localparam int SPRITE_H = 105;

  localparam int KICK_R_X_LO = 47;
  localparam int KICK_R_X_HI = SPRITE_W;
  localparam int KICK_L_X_LO = 0;
  localparam int KICK_L_X_HI = 25;
  localparam int KICK_Y_LO   = 77;
  localparam int KICK_Y_HI   = SPRITE_H;

  localparam int BODY_Y_LO        = 7;
  localparam int BODY_Y_HI        = 64;
  localparam int BODY_FRONT_X_LO  = 17;
  localparam int BODY_FRONT_X_HI  = 53;
  localparam int BODY_BACK_X_LO   = 19;
  localparam int BODY_BACK_X_HI   = 55;

  typedef enum logic [1:0] {
    ST_FIGHT      = 2'd0,
    ST_FREEZE     = 2'd1,
    ST_ROUND_END  = 2'd2,
    ST_MATCH_OVER = 2'd3
  } judge_state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2,
    WIN_DRAW = 2'd3
  } winner_e;

  function automatic logic is_kick_pose(input logic [2:0] pose);
    return (pose == POSE_KICK_R) || (pose == POSE_KICK_L);
  endfunction

  // Facing-away poses shift the body box two pixels to the right.
  function automatic logic is_back_pose(input logic [2:0] pose);
    return (pose == POSE_BACK_GROUND) || (pose == POSE_BACK_JUMP) || (pose == POSE_KICK_L);
  endfunction

endpackage

// File: rtl/hitbox_overlap.sv
// Combinational inclusive rectangle intersect: rectangles touching on an
// edge pixel count as overlapping; a_valid gates the result.
module hitbox_overlap #(
  parameter int W = 11
) (
  input  logic         a_valid,
  input  logic [W-1:0] a_l,
  input  logic [W-1:0] a_r,
  input  logic [W-1:0] a_t,
  input  logic [W-1:0] a_b,
  input  logic [W-1:0] b_l,
  input  logic [W-1:0] b_r,
  input  logic [W-1:0] b_t,
  input  logic [W-1:0] b_b,
  output logic         overlap
);

  logic disjoint;

  always_comb begin
    disjoint = (a_l > b_r) || (b_l > a_r) || (a_t > b_b) || (b_t > a_b);
    overlap  = a_valid && !disjoint;
  end

endmodule

// File: rtl/hit_judge.sv
// Fight judge: detects landed kicks on frame ticks, applies damage, freezes
// play after each hit and tracks rounds. Optional HIT_JUDGE_DOUBLE_KO_EN.
module hit_judge
  import divekick_pkg::*;
#(
  parameter int COORD_W       = 10,
  parameter int HEALTH_MAX    = 144,
  parameter int DAMAGE        = 8,
  parameter int FREEZE_FRAMES = 30,
  parameter int ROUNDS_TO_WIN = 3
) (
  input  logic                                 Clk,
  input  logic                                 Reset,
  input  logic                                 frame_clk,
  input  logic [2:0]                           p1_state,
  input  logic [2:0]                           p2_state,
  input  logic [COORD_W-1:0]                   player1_X_Pos,
  input  logic [COORD_W-1:0]                   player1_Y_Pos,
  input  logic [COORD_W-1:0]                   player2_X_Pos,
  input  logic [COORD_W-1:0]                   player2_Y_Pos,
  output logic                                 Freeze,
  output logic [$clog2(HEALTH_MAX+1)-1:0]      p1_health,
  output logic [$clog2(HEALTH_MAX+1)-1:0]      p2_health,
  output logic [$clog2(ROUNDS_TO_WIN+1)-1:0]   p1_rounds,
  output logic [$clog2(ROUNDS_TO_WIN+1)-1:0]   p2_rounds,
  output logic                                 hit_p1,
  output logic                                 hit_p2,
  output logic                                 match_over,
  output logic [1:0]                           winner
);

  // One extra bit keeps boxes near the right/bottom screen edge from wrapping.
  localparam int CW = COORD_W + 1;
  localparam int HW = $clog2(HEALTH_MAX + 1);
  localparam int RW = $clog2(ROUNDS_TO_WIN + 1);
  localparam int FW = (FREEZE_FRAMES > 0) ? $clog2(FREEZE_FRAMES + 1) : 1;

  localparam logic [HW-1:0] HEALTH_FULL = HW'(HEALTH_MAX);
  localparam logic [RW-1:0] ROUNDS_FULL = RW'(ROUNDS_TO_WIN);
  localparam logic [FW-1:0] FREEZE_LOAD = FW'(FREEZE_FRAMES);

  typedef struct packed {
    logic [CW-1:0] l;
    logic [CW-1:0] r;
    logic [CW-1:0] t;
    logic [CW-1:0] b;
  } rect_t;

  function automatic rect_t kick_rect(input logic [2:0] pose,
                                      input logic [COORD_W-1:0] x,
                                      input logic [COORD_W-1:0] y);
    rect_t         rc;
    logic [CW-1:0] xe;
    logic [CW-1:0] ye;
    xe = {1'b0, x};
    ye = {1'b0, y};
    if (pose == POSE_KICK_L) begin
      rc.l = xe + CW'(KICK_L_X_LO);
      rc.r = xe + CW'(KICK_L_X_HI);
    end else begin
      rc.l = xe + CW'(KICK_R_X_LO);
      rc.r = xe + CW'(KICK_R_X_HI);
    end
    rc.t = ye + CW'(KICK_Y_LO);
    rc.b = ye + CW'(KICK_Y_HI);
    return rc;
  endfunction

  function automatic rect_t body_rect(input logic [2:0] pose,
                                      input logic [COORD_W-1:0] x,
                                      input logic [COORD_W-1:0] y);
    rect_t         rc;
    logic [CW-1:0] xe;
    logic [CW-1:0] ye;
    xe = {1'b0, x};
    ye = {1'b0, y};
    if (is_back_pose(pose)) begin
      rc.l = xe + CW'(BODY_BACK_X_LO);
      rc.r = xe + CW'(BODY_BACK_X_HI);
    end else begin
      rc.l = xe + CW'(BODY_FRONT_X_LO);
      rc.r = xe + CW'(BODY_FRONT_X_HI);
    end
    rc.t = ye + CW'(BODY_Y_LO);
    rc.b = ye + CW'(BODY_Y_HI);
    return rc;
  endfunction

  function automatic logic [HW-1:0] take_damage(input logic [HW-1:0] h);
    if (int'(h) > DAMAGE) return h - HW'(DAMAGE);
    else                  return '0;
  endfunction

  function automatic logic [RW-1:0] round_inc(input logic [RW-1:0] r);
    return (r == ROUNDS_FULL) ? r : r + RW'(1);
  endfunction

  // Hit boxes
  rect_t p1_kick_d, p1_kick_q, p2_kick_d, p2_kick_q;
  rect_t p1_body_d, p1_body_q, p2_body_d, p2_body_q;
  logic  p1_kick_v_d, p1_kick_v_q, p2_kick_v_d, p2_kick_v_q;
  logic  p1_lands_ov, p2_lands_ov;
  logic  p1_lands, p2_lands;

  // Frame tick detector
  logic frame_sync_d, frame_sync_q;
  logic frame_prev_d, frame_prev_q;
  logic tick_d, tick_q;

  // Judge state
  judge_state_e  state_d, state_q;
  logic [FW-1:0] cnt_d, cnt_q;
  logic [HW-1:0] p1_health_d, p1_health_q, p2_health_d, p2_health_q;
  logic [RW-1:0] p1_rounds_d, p1_rounds_q, p2_rounds_d, p2_rounds_q;
  logic          hit_p1_d, hit_p1_q, hit_p2_d, hit_p2_q;

  always_comb begin
    p1_kick_d    = kick_rect(p1_state, player1_X_Pos, player1_Y_Pos);
    p2_kick_d    = kick_rect(p2_state, player2_X_Pos, player2_Y_Pos);
    p1_body_d    = body_rect(p1_state, player1_X_Pos, player1_Y_Pos);
    p2_body_d    = body_rect(p2_state, player2_X_Pos, player2_Y_Pos);
    p1_kick_v_d  = is_kick_pose(p1_state);
    p2_kick_v_d  = is_kick_pose(p2_state);
    frame_sync_d = frame_clk;
    frame_prev_d = frame_sync_q;
    tick_d       = frame_sync_q && !frame_prev_q;
  end

  // NOTE: pure datapath registers carry no reset; they are fully rewritten
  // from the inputs every cycle and nothing reads them before that.
  always_ff @(posedge Clk) begin
    p1_kick_q   <= p1_kick_d;
    p2_kick_q   <= p2_kick_d;
    p1_body_q   <= p1_body_d;
    p2_body_q   <= p2_body_d;
    p1_kick_v_q <= p1_kick_v_d;
    p2_kick_v_q <= p2_kick_v_d;
  end

  hitbox_overlap #(.W(CW)) u_p1_attacks (
    .a_valid (p1_kick_v_q),
    .a_l     (p1_kick_q.l),
    .a_r     (p1_kick_q.r),
    .a_t     (p1_kick_q.t),
    .a_b     (p1_kick_q.b),
    .b_l     (p2_body_q.l),
    .b_r     (p2_body_q.r),
    .b_t     (p2_body_q.t),
    .b_b     (p2_body_q.b),
    .overlap (p1_lands_ov)
  );

  hitbox_overlap #(.W(CW)) u_p2_attacks (
    .a_valid (p2_kick_v_q),
    .a_l     (p2_kick_q.l),
    .a_r     (p2_kick_q.r),
    .a_t     (p2_kick_q.t),
    .a_b     (p2_kick_q.b),
    .b_l     (p1_body_q.l),
    .b_r     (p1_body_q.r),
    .b_t     (p1_body_q.t),
    .b_b     (p1_body_q.b),
    .overlap (p2_lands_ov)
  );

`ifdef HIT_JUDGE_DOUBLE_KO_EN
  assign p1_lands = p1_lands_ov;
  assign p2_lands = p2_lands_ov;
`else
  // Player 1 wins a simultaneous exchange.
  assign p1_lands = p1_lands_ov;
  assign p2_lands = p2_lands_ov && !p1_lands_ov;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_sync_q <= 1'b0;
      frame_prev_q <= 1'b0;
      tick_q       <= 1'b0;
      state_q      <= ST_FIGHT;
      cnt_q        <= '0;
      p1_health_q  <= HEALTH_FULL;
      p2_health_q  <= HEALTH_FULL;
      p1_rounds_q  <= '0;
      p2_rounds_q  <= '0;
      hit_p1_q     <= 1'b0;
      hit_p2_q     <= 1'b0;
    end else begin
      frame_sync_q <= frame_sync_d;
      frame_prev_q <= frame_prev_d;
      tick_q       <= tick_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      p1_health_q  <= p1_health_d;
      p2_health_q  <= p2_health_d;
      p1_rounds_q  <= p1_rounds_d;
      p2_rounds_q  <= p2_rounds_d;
      hit_p1_q     <= hit_p1_d;
      hit_p2_q     <= hit_p2_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p1_health_d = p1_health_q;
    p2_health_d = p2_health_q;
    p1_rounds_d = p1_rounds_q;
    p2_rounds_d = p2_rounds_q;
    hit_p1_d    = 1'b0;
    hit_p2_d    = 1'b0;
    case (state_q)
      ST_FIGHT: begin
        if (tick_q && (p1_lands || p2_lands)) begin
          hit_p1_d = p1_lands;
          hit_p2_d = p2_lands;
          if (p1_lands) p2_health_d = take_damage(p2_health_q);
          if (p2_lands) p1_health_d = take_damage(p1_health_q);
          cnt_d   = FREEZE_LOAD;
          state_d = ST_FREEZE;
        end
      end
      ST_FREEZE: begin
        if (tick_q) begin
          // A count of 1 or 0 means this tick is the last frozen frame.
          if (cnt_q <= FW'(1)) begin
            cnt_d   = '0;
            state_d = (p1_health_q == '0 || p2_health_q == '0) ? ST_ROUND_END : ST_FIGHT;
          end else begin
            cnt_d = cnt_q - FW'(1);
          end
        end
      end
      ST_ROUND_END: begin
        if (p2_health_q == '0) p1_rounds_d = round_inc(p1_rounds_q);
        if (p1_health_q == '0) p2_rounds_d = round_inc(p2_rounds_q);
        p1_health_d = HEALTH_FULL;
        p2_health_d = HEALTH_FULL;
        state_d = (p1_rounds_d == ROUNDS_FULL || p2_rounds_d == ROUNDS_FULL) ?
                  ST_MATCH_OVER : ST_FIGHT;
      end
      ST_MATCH_OVER: ;
      default: state_d = ST_FIGHT;
    endcase
  end

  always_comb begin
    Freeze     = 1'b0;
    match_over = 1'b0;
    winner     = WIN_NONE;
    case (state_q)
      ST_FREEZE: Freeze = 1'b1;
      ST_MATCH_OVER: begin
        Freeze     = 1'b1;
        match_over = 1'b1;
        if (p1_rounds_q == ROUNDS_FULL && p2_rounds_q == ROUNDS_FULL) winner = WIN_DRAW;
        else if (p1_rounds_q == ROUNDS_FULL)                         winner = WIN_P1;
        else                                                          winner = WIN_P2;
      end
      default: ;
    endcase
  end

  assign p1_health = p1_health_q;
  assign p2_health = p2_health_q;
  assign p1_rounds = p1_rounds_q;
  assign p2_rounds = p2_rounds_q;
  assign hit_p1    = hit_p1_q;
  assign hit_p2    = hit_p2_q;

endmodule
